// File: rtl/monitor_decimal_multimodo.sv
// monitor_decimal_multimodo
// Shows an ANCHO-bit switch word in decimal on a DIGITOS-digit multiplexed
// 7-segment display. The word is read as unsigned (modo=0) or as
// two's-complement signed (modo=1). A sequential double-dabble engine makes
// the conversion, one bit per cycle. Leading zeros are blanked, and a minus
// sign sits directly left of the most significant digit.
module monitor_decimal_multimodo #(
    parameter int ANCHO        = 8,
    parameter int DIGITOS      = 4,
    parameter int DIV_REFRESCO = 16
) (
    input  logic               clock_placa,
    input  logic               reset_n,
    input  logic [ANCHO-1:0]   switches,
    input  logic               modo,
    output logic [7:0]         reg7SEG,
    output logic [DIGITOS-1:0] sel_pantalla,
    output logic               ocupado
);

    localparam int BCD_W = 4 * DIGITOS;
    localparam int CNT_W = $clog2(ANCHO + 1);
    localparam int PRE_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam int IDX_W = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

    // Conversion controller. The state is kept in a named enum so that
    // checkers can bind to it directly.
    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        DESPLAZA  = 2'd1,
        ACTUALIZA = 2'd2
    } estado_t;

    estado_t estado;
    estado_t estado_sig;
    logic    ocupado_sig;

    // Last value converted. Changed inputs are detected against this value.
    logic [ANCHO-1:0] ult_sw;
    logic             ult_modo;

    // Inputs as captured at the start of the conversion now running.
    logic [ANCHO-1:0] cap_sw;
    logic             cap_modo;

    // Double-dabble working registers.
    logic [ANCHO-1:0]       operando;
    logic [BCD_W-1:0]       bcd;
    logic [BCD_W-1:0]       bcd_aj;
    logic [BCD_W+ANCHO-1:0] desplazado;
    logic [CNT_W-1:0]       pasos;
    logic                   signo;

    // Display latch. It is written in one cycle, so a scan never shows
    // half of a conversion.
    logic [BCD_W-1:0] latch_bcd;
    logic             latch_signo;

    // Scan state.
    logic [PRE_W-1:0] prescaler;
    logic [IDX_W-1:0] indice;
    logic [7:0]       seg_sig;
    logic [DIGITOS-1:0] sel_sig;

    // Operand preparation. In signed mode a negative word is replaced by
    // its magnitude (-x mod 2^ANCHO), so the most negative value still
    // converts correctly as an unsigned magnitude.
    logic             cambio;
    logic             negativo;
    logic [ANCHO-1:0] magnitud;

    assign cambio   = ({modo, switches} != {ult_modo, ult_sw});
    assign negativo = modo & switches[ANCHO-1];
    assign magnitud = negativo ? (~switches + ANCHO'(1)) : switches;

    // Segment code for one decimal digit, active-low, with dp off.
    function automatic logic [7:0] codigo_7seg(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // Controller state register. ocupado is registered from the next state,
    // so it is high exactly while the engine is away from REPOSO.
    always_ff @(posedge clock_placa or negedge reset_n) begin
        if (!reset_n) begin
            estado  <= REPOSO;
            ocupado <= 1'b0;
        end else begin
            estado  <= estado_sig;
            ocupado <= ocupado_sig;
        end
    end

    // Next-state logic: idle until the inputs differ from the last value
    // converted, shift ANCHO times, then publish the result for one cycle.
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: begin
                if (cambio) begin
                    estado_sig = DESPLAZA;
                end
            end
            DESPLAZA: begin
                if (pasos == CNT_W'(1)) begin
                    estado_sig = ACTUALIZA;
                end
            end
            ACTUALIZA: begin
                estado_sig = REPOSO;
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
        ocupado_sig = (estado_sig != REPOSO);
    end

    // Double-dabble step: add 3 to every nibble of 5 or more, then shift
    // {BCD, operand} left by one. The top BCD bit drops out of the shift.
    always_comb begin
        bcd_aj = bcd;
        for (int i = 0; i < DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        desplazado = {bcd_aj, operando} << 1;
    end

    // Conversion datapath: capture, shift, and publish to the display latch.
    always_ff @(posedge clock_placa or negedge reset_n) begin
        if (!reset_n) begin
            ult_sw      <= '0;
            ult_modo    <= 1'b0;
            cap_sw      <= '0;
            cap_modo    <= 1'b0;
            operando    <= '0;
            bcd         <= '0;
            pasos       <= '0;
            signo       <= 1'b0;
            latch_bcd   <= '0;
            latch_signo <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (cambio) begin
                        cap_sw   <= switches;
                        cap_modo <= modo;
                        operando <= magnitud;
                        signo    <= negativo;
                        bcd      <= '0;
                        pasos    <= CNT_W'(ANCHO);
                    end
                end
                DESPLAZA: begin
                    bcd      <= desplazado[BCD_W+ANCHO-1:ANCHO];
                    operando <= desplazado[ANCHO-1:0];
                    pasos    <= pasos - CNT_W'(1);
                end
                ACTUALIZA: begin
                    latch_bcd   <= bcd;
                    latch_signo <= signo;
                    // The captured inputs are stored, not the current ones,
                    // so a change made during the conversion is picked up
                    // on return to REPOSO.
                    ult_sw      <= cap_sw;
                    ult_modo    <= cap_modo;
                end
                default: begin
                end
            endcase
        end
    end

    // Scan timing: each digit is held DIV_REFRESCO cycles, and the index
    // walks from the rightmost digit to the leftmost.
    always_ff @(posedge clock_placa or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            indice    <= '0;
        end else if (prescaler == PRE_W'(DIV_REFRESCO - 1)) begin
            prescaler <= '0;
            if (indice == IDX_W'(DIGITOS - 1)) begin
                indice <= '0;
            end else begin
                indice <= indice + IDX_W'(1);
            end
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Pattern for the selected digit: a number up to the most significant
    // nonzero digit (digit 0 always), the minus sign just left of it, and
    // blank elsewhere.
    always_comb begin
        int         msd;
        logic [3:0] nibble;
        msd    = 0;
        nibble = 4'd0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (latch_bcd[4*i +: 4] != 4'd0) begin
                msd = i;
            end
            if (i == int'(indice)) begin
                nibble = latch_bcd[4*i +: 4];
            end
        end
        if (int'(indice) <= msd) begin
            seg_sig = codigo_7seg(nibble);
        end else if ((int'(indice) == msd + 1) && latch_signo) begin
            seg_sig = 8'hBF;
        end else begin
            seg_sig = 8'hFF;
        end
        sel_sig = ~(DIGITOS'(1) << indice);
    end

    // Display outputs are registered every cycle from the index and the latch.
    always_ff @(posedge clock_placa or negedge reset_n) begin
        if (!reset_n) begin
            reg7SEG      <= 8'hFF;
            sel_pantalla <= '1;
        end else begin
            reg7SEG      <= seg_sig;
            sel_pantalla <= sel_sig;
        end
    end

endmodule

// File: doc/monitor_decimal_multimodo.md
# monitor_decimal_multimodo

Parametrised successor to the 8-bit decimal switch monitor. Converts an ANCHO-bit switch word to decimal with a sequential double-dabble engine and shows it on a DIGITOS-digit multiplexed 7-segment display. The word is read as unsigned or two's-complement signed. Leading zeros are blanked, and a minus sign is placed directly left of the most significant digit. Sits between the board switches and the board display; the only clock is the board clock.

## Interface
- ANCHO, 8: switch word width (≥2).
- DIGITOS, 4: number of display digits. Must be ≥ decimal digits of 2^ANCHO−1, plus 1 when signed mode is used.
- DIV_REFRESCO, 16: clock cycles each digit is held during scanning (≥1).
- clock_placa  input  1  board clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- switches  input  ANCHO  value to display; already synchronous to clock_placa.
- modo  input  1  0 = unsigned, 1 = two's-complement signed.
- reg7SEG  output  8  segment pattern, active-low; bit0..6 = a..g, bit7 = dp (always 1).
- sel_pantalla  output  DIGITOS  digit enable, one-hot active-low; bit 0 = rightmost digit.
- ocupado  output  1  high while a conversion is in progress.

## Operation
- **FSM states:** REPOSO, DESPLAZA, ACTUALIZA.
- **REPOSO:**
  - Compares {modo, switches} with the last converted {modo, switches}.
  - On mismatch, captures the operand and goes to DESPLAZA with its step counter set to ANCHO.
  - In signed mode with a negative operand, it captures the magnitude −x modulo 2^ANCHO and sets the sign flag. Example: 8'h80 gives magnitude 128.
  - Otherwise it captures x and clears the sign flag.
- **DESPLAZA:** one step per cycle. Add 3 to every BCD nibble ≥5, then shift {BCD, operand} left by 1. After ANCHO steps, go to ACTUALIZA.
- **ACTUALIZA:**
  - Writes the BCD result and sign into the display latch in a single cycle, so the display never shows a partial result.
  - Stores {modo, switches} as captured (not the current inputs) as the last converted value.
  - Returns to REPOSO.
- Input changes during DESPLAZA and ACTUALIZA are ignored. If the inputs differ from the stored value on return to REPOSO, the block reconverts.
- **Display mapping per digit i**, with m = index of the most significant nonzero digit (m = 0 for value 0):
  - i ≤ m: decimal digit.
  - i = m+1 and sign set: minus, 8'hBF.
  - all other i: blank, 8'hFF.
  - Digit 0 is always shown.
- **Segment codes:** 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
- **Scan:**
  - A prescaler counts 0..DIV_REFRESCO−1.
  - At terminal count, the digit index advances 0→1→…→DIGITOS−1→0.
  - reg7SEG and sel_pantalla are registered from (index, latch) every cycle.
- **Reset values:** FSM REPOSO; last converted value 0, modo 0; display latch 0, sign 0; index 0; prescaler 0; reg7SEG 8'hFF; sel_pantalla all ones; ocupado 0.

## Timing
- **Conversion latency:** capture edge k; the latch updates at edge k+ANCHO+1.
- **ocupado:** high from edge k through edge k+ANCHO+1, i.e. ANCHO+1 cycles. It is registered and low in REPOSO.
- **Scan latency:** outputs reflect a new index or latch content one cycle later.
  - First valid output: first edge after reset release, showing digit 0.
  - Each digit is held DIV_REFRESCO cycles.
  - Full frame: DIGITOS·DIV_REFRESCO cycles.
- **Nonzero inputs at reset release:** a mismatch is seen on the first edge, so conversion starts on that edge.
- **Reset mid-conversion:** all state returns to reset values immediately, without waiting for a clock. The partial result is discarded and the latch reads 0.
- **Mode change alone** (same switches) triggers a reconversion.

## Test plan
Bench settings: ANCHO=8, DIGITOS=4, DIV_REFRESCO=4, 4 ns clock.
1. Reset with switches=0, modo=0 → ocupado stays 0; scan shows digit0 C0 and digits 1–3 FF; sel_pantalla cycles E, D, B, 7, each held 4 cycles.
2. switches=8'hFE, modo=0 → ocupado high exactly 9 cycles, latch updated 9 edges after capture; display d0 99, d1 92, d2 A4, d3 FF (254).
3. modo=1 with 8'hFE → d0 A4, d1 BF, d2/d3 FF (−2). Then 8'h80 → d0 80, d1 A4, d2 F9, d3 BF (−128).
4. switches=8'h62, modo=0 → d0 80, d1 90, d2/d3 FF (98). Then modo=1 → identical digits (98), and a reconversion is observed on ocupado.
5. switches=8'h0A; 3 cycles after capture change to 8'h07 → display first shows 10 (d0 C0, d1 F9), then a second conversion starts on return to REPOSO and the display ends at 7 (d0 F8, d1 FF).
6. Assert reset_n mid-DESPLAZA → reg7SEG=FF, sel_pantalla=F, ocupado=0 immediately. On release with switches held, a new conversion starts on the first edge and completes normally.
